// File: rtl/adc_pkg.sv
// Shared types and helpers for the multi-channel serial ADC receiver.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
package adc_pkg;

  // Frame sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_QUIET = 3'd4
  } adc_state_t;

  // Default timing, matching the top-level parameter defaults.
  localparam int DEF_CLK_DIV   = 16;
  localparam int DEF_FRAME_W   = 16;
  localparam int DEF_QUIET_CYC = 8;

  // Counter widths for the default configuration.
  localparam int DIV_CNT_W   = $clog2(DEF_CLK_DIV);
  localparam int HP_CNT_W    = $clog2(2 * DEF_FRAME_W);
  localparam int QUIET_CNT_W = $clog2(DEF_QUIET_CYC + 1);

  // Width needed to count 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Midscale code of an unsigned converter of the given width.
  function automatic logic [31:0] midscale(input int width);
    return 32'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/adc_serial_rx_if.sv
// Pin and result bundle between the ADC receiver and its controller.
// Latency: n/a (wiring only).
// Backpressure: none; results are strobed and must be taken on data_valid.
interface adc_serial_rx_if #(
  parameter int N_CH   = 2,
  parameter int DATA_W = 12
);

  logic                     start;
  logic                     cont;
  logic [N_CH-1:0]          sdata;
  logic                     sclk;
  logic                     cs_n;
  logic                     busy;
  logic                     data_valid;
  logic [N_CH*DATA_W-1:0]   dataout;
  logic [N_CH-1:0]          frame_err;

  // Controller / board side: issues triggers and drives the ADC data lines.
  modport master (
    output start, cont, sdata,
    input  sclk, cs_n, busy, data_valid, dataout, frame_err
  );

  // Receiver side.
  modport slave (
    input  start, cont, sdata,
    output sclk, cs_n, busy, data_valid, dataout, frame_err
  );

endinterface

// File: rtl/adc_sclk_gen.sv
// Serial clock generator: divides clk into sclk half-periods while enabled.
// Latency: sclk is registered; it drops low on the edge where en first rises.
// Backpressure: none; en is a level, sclk parks high whenever en is low.
module adc_sclk_gen
  import adc_pkg::*;
#(
  parameter int CLK_DIV = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,        // high for every cycle sclk should be running
  output logic sclk,
  output logic tick,      // last clk cycle of a half-period
  output logic rise_evt,  // this edge takes sclk 0->1
  output logic fall_evt   // this edge takes sclk 1->0
);

  localparam int DIV_W = cnt_w(CLK_DIV);

  logic [DIV_W-1:0] div_q, div_d;
  logic             sclk_q, sclk_d;
  logic             en_q, en_d;
  logic             wrap;

  // The half-period end depends only on registered state, so the sequencer
  // can use it to decide its next state without a combinational loop.
  assign wrap     = en_q && (div_q == DIV_W'(CLK_DIV - 1));
  assign tick     = wrap;
  assign rise_evt = wrap && !sclk_q;
  assign sclk     = sclk_q;

  // Divider and sclk toggle; a half-period end that coincides with en
  // dropping leaves sclk high instead of toggling.
  always_comb begin
    en_d     = en;
    div_d    = div_q;
    sclk_d   = sclk_q;
    fall_evt = 1'b0;
    if (!en) begin
      div_d  = '0;
      sclk_d = 1'b1;
    end else if (!en_q) begin
      div_d    = '0;
      sclk_d   = 1'b0;
      fall_evt = 1'b1;
    end else if (wrap) begin
      div_d    = '0;
      sclk_d   = ~sclk_q;
      fall_evt = sclk_q;
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  // Divider state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q  <= '0;
      sclk_q <= 1'b1;
      en_q   <= 1'b0;
    end else begin
      div_q  <= div_d;
      sclk_q <= sclk_d;
      en_q   <= en_d;
    end
  end

endmodule

// File: rtl/adc_serial_rx.sv
// Multi-channel serial ADC receiver: frames cs_n/sclk, shifts N_CH lines, strobes results.
// Latency: start to data_valid = 1 + CLK_DIV*(2*FRAME_W+2) cycles.
// Backpressure: none; start is dropped while busy, results held until the next strobe.
module adc_serial_rx
  import adc_pkg::*;
#(
  parameter int N_CH      = 2,
  parameter int FRAME_W   = 16,
  parameter int DATA_W    = 12,
  parameter int CLK_DIV   = 16,
  parameter int QUIET_CYC = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  adc_serial_rx_if.slave bus
);

  localparam int DIV_W  = cnt_w(CLK_DIV);
  localparam int QW     = cnt_w(QUIET_CYC + 1);
  localparam int CNT_W  = (DIV_W > QW) ? DIV_W : QW;
  localparam int HP_W   = cnt_w(2 * FRAME_W);
  localparam int LEAD_W = FRAME_W - DATA_W;
  localparam logic [DATA_W-1:0] MID = DATA_W'(midscale(DATA_W));

  adc_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [HP_W-1:0]   hp_q, hp_d;
  logic              cs_n_q, cs_n_d;
  logic              busy_q, busy_d;
  logic              dv_q, dv_d;
  logic              load;

  logic              gen_en;
  logic              sclk;
  logic              tick;
  logic              rise_evt;
  logic              fall_evt;

  logic [FRAME_W-1:0] shreg_q [N_CH];
  logic [FRAME_W-1:0] shreg_d [N_CH];
  logic [DATA_W-1:0]  data_q  [N_CH];
  logic [DATA_W-1:0]  data_d  [N_CH];
  logic               err_q   [N_CH];
  logic               err_d   [N_CH];
  logic [N_CH-1:0]    lead_or;

  // sclk runs for exactly the cycles the sequencer spends in SHIFT.
  assign gen_en = (state_d == ST_SHIFT);

  adc_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (gen_en),
    .sclk     (sclk),
    .tick     (tick),
    .rise_evt (rise_evt),
    .fall_evt (fall_evt)
  );

  // Frame sequencer: phase timing, chip select, busy and the result strobe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cs_n_d  = cs_n_q;
    busy_d  = busy_q;
    dv_d    = 1'b0;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cs_n_d = 1'b1;
        busy_d = 1'b0;
        if (bus.start || bus.cont) begin
          state_d = ST_SETUP;
          cnt_d   = '0;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      ST_SETUP: begin
        if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SHIFT: begin
        if (tick && (hp_q == HP_W'(2 * FRAME_W - 1))) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      end
      ST_HOLD: begin
        if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
          state_d = ST_QUIET;
          cnt_d   = '0;
          cs_n_d  = 1'b1;
          dv_d    = 1'b1;
          load    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_QUIET: begin
        if (cnt_q == CNT_W'(QUIET_CYC - 1)) begin
          cnt_d = '0;
          if (bus.cont) begin
            state_d = ST_SETUP;
            cs_n_d  = 1'b0;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        cs_n_d  = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Half-period counter: restarts on the opening sclk fall, advances per half-period.
  always_comb begin
    hp_d = hp_q;
    if (fall_evt && (state_q != ST_SHIFT)) begin
      hp_d = '0;
    end else if ((state_q == ST_SHIFT) && tick) begin
      hp_d = hp_q + 1'b1;
    end
  end

  // Sequencer and control output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hp_q    <= '0;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      dv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hp_q    <= hp_d;
      cs_n_q  <= cs_n_d;
      busy_q  <= busy_d;
      dv_q    <= dv_d;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch

    // Leading bits of the frame must be zero for a well-formed conversion.
    if (LEAD_W > 0) begin : g_lead
      assign lead_or[k] = |shreg_q[k][FRAME_W-1:DATA_W];
    end else begin : g_nolead
      assign lead_or[k] = 1'b0;
    end

    // Shift in one bit per rising sclk; capture result and error at frame end.
    always_comb begin
      shreg_d[k] = shreg_q[k];
      data_d[k]  = data_q[k];
      err_d[k]   = err_q[k];
      if (rise_evt) begin
        shreg_d[k] = {shreg_q[k][FRAME_W-2:0], bus.sdata[k]};
      end
      if (load) begin
        data_d[k] = shreg_q[k][DATA_W-1:0];
        err_d[k]  = lead_or[k];
      end
    end

    // Per-channel shift register and held result.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        shreg_q[k] <= '0;
        data_q[k]  <= MID;
        err_q[k]   <= 1'b0;
      end else begin
        shreg_q[k] <= shreg_d[k];
        data_q[k]  <= data_d[k];
        err_q[k]   <= err_d[k];
      end
    end

    assign bus.dataout[k*DATA_W +: DATA_W] = data_q[k];
    assign bus.frame_err[k]                = err_q[k];
  end

  assign bus.sclk       = sclk;
  assign bus.cs_n       = cs_n_q;
  assign bus.busy       = busy_q;
  assign bus.data_valid = dv_q;

endmodule

// File: doc/adc_serial_rx.md
# adc_serial_rx

Parametrised multi-channel serial ADC receiver (ADCS7476 / Pmod AD1 style): generates its own `sclk` and active-low chip-select from the system clock. It shifts in `N_CH` parallel serial data lines per frame and presents the `DATA_W` LSBs of each channel with a one-cycle valid strobe. It supports single-shot and continuous conversion, a programmable quiet gap, and per-channel leading-zero error checking. It sits between the ADC pins and the servo control loop, replacing the single-channel fixed 12-bit receiver.

## Interface
- `N_CH`, 2: number of ADC data lines sharing `sclk`/`cs_n`.
- `FRAME_W`, 16: `sclk` periods per frame (≥ `DATA_W`).
- `DATA_W`, 12: result bits, taken as the last `DATA_W` bits of the frame.
- `CLK_DIV`, 16: `clk` cycles per `sclk` half-period (≥ 2).
- `QUIET_CYC`, 8: minimum `clk` cycles `cs_n` stays high between frames (≥ 1).

Ports:
- `clk` in 1: system clock; the only clock.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle request for a single conversion.
- `cont` in 1: level; while high, frames run back-to-back.
- `sdata` in `N_CH`: serial data from the ADCs, MSB first.
- `sclk` out 1: serial clock to the ADCs, idles high.
- `cs_n` out 1: chip select, active low.
- `busy` out 1: high from trigger acceptance until end of the quiet gap.
- `data_valid` out 1: one-cycle strobe when new data is on `dataout`.
- `dataout` out `N_CH*DATA_W`: channel k at bits [k*DATA_W +: DATA_W].
- `frame_err` out `N_CH`: bit k set if any leading (`FRAME_W-DATA_W`) bit of channel k was 1.

## Operation
- FSM states: IDLE, SETUP, SHIFT, HOLD, QUIET.
- IDLE: `sclk`=1, `cs_n`=1, `busy`=0. Trigger = `start | cont`. On trigger, the next state is SETUP, with `cs_n`=0 and `busy`=1 from the next cycle.
- SETUP: `CLK_DIV` cycles, `sclk`=1.
- SHIFT: `2*FRAME_W` half-periods of `CLK_DIV` cycles each, starting with `sclk`=0.
  - At the clk edge where `sclk` goes 0→1, every line is sampled: `shreg[k] <= {shreg[k][FRAME_W-2:0], sdata[k]}`.
  - `sdata` is not synchronised; it is source-synchronous to `sclk` and is given `CLK_DIV` cycles to settle after each falling edge.
- HOLD: `CLK_DIV` cycles, `sclk`=1.
- On exit from HOLD:
  - `cs_n` returns to 1.
  - `data_valid` pulses for one cycle.
  - `dataout` loads the low `DATA_W` bits of each shift register.
  - `frame_err` loads the OR of each register's upper bits.
- QUIET: `QUIET_CYC` cycles with `cs_n`=1. At the end:
  - if `cont`=1, go directly to SETUP (`busy` stays 1);
  - otherwise go to IDLE.
- `start` is ignored while `busy`=1 and is not queued.
- `cont` falling mid-frame: the current frame completes and its data is delivered; no further frame starts.
- `start` and `cont` together in IDLE: exactly one trigger; `cont` governs continuation.
- `dataout`/`frame_err` hold their values between strobes.

## Timing
- Reset values:
  - `sclk`=1, `cs_n`=1, `busy`=0, `data_valid`=0, `frame_err`=0.
  - Each channel of `dataout` = midscale (1 << (`DATA_W`-1)), e.g. 12'h800.
  - State IDLE; divider and bit counters 0.
- Reset asserted mid-frame: all of the above apply at the next `clk` edge. The partial frame is discarded and no `data_valid` is produced.
- `cs_n` low duration = `CLK_DIV*(2*FRAME_W+2)` cycles.
- `data_valid` occurs in the same cycle `cs_n` rises.
- `cs_n` high between continuous frames = `QUIET_CYC` cycles (SETUP follows immediately).
- Continuous frame period = `CLK_DIV*(2*FRAME_W+2) + QUIET_CYC` cycles.
- Single-shot latency, `start` to `data_valid` = `1 + CLK_DIV*(2*FRAME_W+2)` cycles.
- All outputs are registered; no combinational input-to-output paths.

## Structure
- Package `adc_pkg`:
  - state enum `adc_state_t`;
  - function `midscale(width)`;
  - localparams for counter widths: `$clog2(CLK_DIV)`, `$clog2(2*FRAME_W)`, `$clog2(QUIET_CYC+1)`.
- Sub-module `adc_sclk_gen`:
  - half-period divider;
  - drives `sclk`;
  - emits one-cycle `rise_evt`/`fall_evt` strobes;
  - enabled only in SHIFT and held high otherwise.
- The top contains the FSM, the half-period/quiet counters, and a generate loop of `N_CH` shift registers with error reduction.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles.
  - Required: `sclk`=1, `cs_n`=1, `busy`=0, `data_valid`=0, each `dataout` channel = 12'h800.
- Single shot (`CLK_DIV`=2, `FRAME_W`=16, `N_CH`=2): ADC models drive 16'h0A5C and 16'h0FFF.
  - `data_valid` exactly 69 cycles after `start`.
  - `dataout` = {12'hFFF, 12'hA5C}; `frame_err`=0.
  - `cs_n` low for 68 cycles.
- Continuous: `cont`=1 for 3 frames with incrementing codes.
  - Three strobes spaced 68+`QUIET_CYC` cycles apart, in-order values.
  - Drop `cont` mid-frame 3: that frame is still delivered, then IDLE.
- Error: channel 1 drives leading bits 4'b0100 with code 12'h123.
  - `frame_err`=2'b10; `dataout` ch1 = 12'h123.
- Corner: `start` pulse while `busy` is ignored (no extra frame). Assert `rst_n`=0 during SHIFT bit 7:
  - no strobe;
  - `dataout` returns to midscale;
  - `cs_n`=1 the next cycle.
